// File: rtl/err_cnt_pkg.sv
// Shared types and default sizing for the per-chain error counter readout block.
package err_cnt_pkg;

  localparam int DEF_NUM_CH      = 20;
  localparam int DEF_CNT_W       = 12;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNAP  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/err_cnt_readout_sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous strobe, plus a one-cycle
// rising-edge pulse on the synchronized level.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/err_cnt_readout.sv
// Per-chain saturating error counters with a snapshot + bit-serial readout
// paced by the RPi. Define ERR_CNT_PARITY_EN to append an XOR parity bit.
module err_cnt_readout
  import err_cnt_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CLR_ON_SNAP = 1
) (
  input  logic              CLK,
  input  logic              RST_B,
  input  logic [NUM_CH-1:0] DUT_Q,
  input  logic [NUM_CH-1:0] EXP_Q,
  input  logic              CMP_EN,
  input  logic              CLR,
  input  logic              SAVE_DATA,
  input  logic              DATA_CLK,
  output logic              DATA_OUT,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic [1:0]        STATE_DBG
);

  localparam int DATA_W = NUM_CH * CNT_W;
`ifdef ERR_CNT_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int IDX_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e state_q, state_d;

  logic save_lvl, save_rise;
  logic dclk_lvl_unused, dclk_rise;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_save_sync (
    .clk_i   (CLK),
    .rst_n_i (RST_B),
    .d_i     (SAVE_DATA),
    .level_o (save_lvl),
    .rise_o  (save_rise)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_dclk_sync (
    .clk_i   (CLK),
    .rst_n_i (RST_B),
    .d_i     (DATA_CLK),
    .level_o (dclk_lvl_unused),
    .rise_o  (dclk_rise)
  );

  // DUT_Q is synchronized; EXP_Q and CMP_EN get the same depth so they line up.
  logic [NUM_CH-1:0]      dut_pipe_q [SYNC_STAGES];
  logic [NUM_CH-1:0]      exp_pipe_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] cmp_pipe_q;

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        dut_pipe_q[s] <= '0;
        exp_pipe_q[s] <= '0;
      end
      cmp_pipe_q <= '0;
    end else begin
      dut_pipe_q[0] <= DUT_Q;
      exp_pipe_q[0] <= EXP_Q;
      cmp_pipe_q[0] <= CMP_EN;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        dut_pipe_q[s] <= dut_pipe_q[s-1];
        exp_pipe_q[s] <= exp_pipe_q[s-1];
        cmp_pipe_q[s] <= cmp_pipe_q[s-1];
      end
    end
  end

  logic [NUM_CH-1:0] mismatch;
  assign mismatch = {NUM_CH{cmp_pipe_q[SYNC_STAGES-1]}} &
                    (dut_pipe_q[SYNC_STAGES-1] ^ exp_pipe_q[SYNC_STAGES-1]);

  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];
  logic             snap;

  assign snap = (state_q == ST_SNAP);

  // Clear-on-snap keeps a mismatch landing in the SNAP cycle as a count of 1.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (CLR) begin
        cnt_d[i] = '0;
      end else if (snap && (CLR_ON_SNAP != 0)) begin
        cnt_d[i] = CNT_W'(mismatch[i]);
      end else if (mismatch[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Channel 0 lands in the top bits so it leaves first, MSB first.
  logic [DATA_W-1:0] cnt_flat;
  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_flat[DATA_W-1-i*CNT_W -: CNT_W] = cnt_q[i];
    end
  end

  logic [FRAME_LEN-1:0] shadow_q, shadow_d, shadow_load;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 last_bit;

`ifdef ERR_CNT_PARITY_EN
  assign shadow_load = {cnt_flat, ^cnt_flat};
`else
  assign shadow_load = cnt_flat;
`endif

  assign last_bit = (idx_q == IDX_W'(FRAME_LEN - 1));

  always_comb begin
    shadow_d = shadow_q;
    idx_d    = idx_q;
    if (state_q == ST_SNAP) begin
      shadow_d = shadow_load;
      idx_d    = '0;
    end else if ((state_q == ST_SHIFT) && dclk_rise) begin
      shadow_d = shadow_q << 1;
      idx_d    = idx_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      shadow_q <= '0;
      idx_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (save_rise) state_d = ST_SNAP;
      ST_SNAP:  state_d = ST_SHIFT;
      ST_SHIFT: if (dclk_rise && last_bit) state_d = ST_DONE;
      ST_DONE:  if (!save_lvl) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY       = (state_q == ST_SNAP) || (state_q == ST_SHIFT);
    FRAME_DONE = (state_q == ST_DONE);
    DATA_OUT   = (state_q == ST_SHIFT) ? shadow_q[FRAME_LEN-1] : 1'b0;
    STATE_DBG  = state_q;
  end

endmodule
